// File: rtl/dest_flow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dest_flow_ctrl_pkg
// Brief    : Shared defaults and pause-FSM state encoding for dest_flow_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package dest_flow_ctrl_pkg;

    // Default geometry: 6-bit words, 8-entry destination FIFOs.
    localparam int DEF_DATA_W = 6;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_CNT_W  = 4;   // clog2(DEF_DEPTH) + 1

    // Per-destination back-pressure state.
    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_PAUSED = 1'b1
    } pause_state_e;

endpackage : dest_flow_ctrl_pkg
`default_nettype wire

// File: rtl/dest_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dest_flow_ctrl_if
// Brief    : Bundle of the input stream, pop strobes, thresholds and all
//            status outputs of dest_flow_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface dest_flow_ctrl_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 4
) ();

    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              pop_d0;
    logic              pop_d1;
    logic [CNT_W-1:0]  umbral_af;
    logic [CNT_W-1:0]  umbral_ae;

    logic              push_d0;
    logic              push_d1;
    logic [DATA_W-1:0] data_out;
    logic              pause_d0;
    logic              pause_d1;
    logic [CNT_W-1:0]  count_d0;
    logic [CNT_W-1:0]  count_d1;
    logic              overflow_err;
    logic              underflow_err;
    logic              idle;

    // Flow controller side.
    modport slave (
        input  valid_in, data_in, pop_d0, pop_d1, umbral_af, umbral_ae,
        output push_d0, push_d1, data_out, pause_d0, pause_d1,
               count_d0, count_d1, overflow_err, underflow_err, idle
    );

    // Upstream/downstream driver side.
    modport master (
        output valid_in, data_in, pop_d0, pop_d1, umbral_af, umbral_ae,
        input  push_d0, push_d1, data_out, pause_d0, pause_d1,
               count_d0, count_d1, overflow_err, underflow_err, idle
    );

endinterface : dest_flow_ctrl_if
`default_nettype wire

// File: rtl/dest_pause_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dest_pause_ctrl
// Brief    : Occupancy tracker, NORMAL/PAUSED hysteresis FSM and sticky
//            error flags for a single destination FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module dest_pause_ctrl
    import dest_flow_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             reset_L,
    input  wire logic             i_push,      // registered push strobe
    input  wire logic             i_pop,       // downstream consumed one entry
    input  wire logic             i_drop,      // push attempt suppressed as full
    input  wire logic [CNT_W-1:0] i_umbral_af,
    input  wire logic [CNT_W-1:0] i_umbral_ae,
    output logic      [CNT_W-1:0] o_count,
    output logic                  o_pause,
    output logic                  o_full,
    output logic                  o_ovf,
    output logic                  o_unf
);

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_depth_m1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_ovf;
    logic             r_unf;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    pause_state_e     r_state;
    pause_state_e     w_state_nxt;

    // Counter next value and error detection; push+pop on one edge nets to zero.
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        if (i_drop) begin
            w_ovf_nxt = 1'b1;
        end
        if (i_push && !i_pop) begin
            if (r_count == c_depth) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + c_one;
            end
        end else if (!i_push && i_pop) begin
            if (r_count == '0) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count - c_one;
            end
        end
    end

    // Occupancy and sticky error registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // Hysteresis: pause at/above af, resume at/below ae, judged on the registered count.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: if (r_count >= i_umbral_af) w_state_nxt = ST_PAUSED;
            ST_PAUSED: if (r_count <= i_umbral_ae) w_state_nxt = ST_NORMAL;
            default:   w_state_nxt = ST_NORMAL;
        endcase
    end

    // Pause FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Full also covers the push already registered but not yet counted.
    assign o_full  = (r_count == c_depth) || (i_push && (r_count == c_depth_m1));
    assign o_count = r_count;
    assign o_pause = (r_state == ST_PAUSED);
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

endmodule : dest_pause_ctrl
`default_nettype wire

// File: rtl/dest_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dest_flow_ctrl
// Brief    : Routes incoming words to one of two destination FIFOs by MSB,
//            registers the push strobe/word, and tracks per-destination
//            occupancy with hysteresis back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module dest_flow_ctrl
    import dest_flow_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic        clk,
    input  wire logic        reset_L,
    dest_flow_ctrl_if.slave  bus_if
);

    logic              w_dest;
    logic              w_req_d0;
    logic              w_req_d1;
    logic              w_full_d0;
    logic              w_full_d1;
    logic              w_push_d0_nxt;
    logic              w_push_d1_nxt;
    logic              w_drop_d0;
    logic              w_drop_d1;
    logic              r_push_d0;
    logic              r_push_d1;
    logic [DATA_W-1:0] r_data_out;
    logic [CNT_W-1:0]  w_count_d0;
    logic [CNT_W-1:0]  w_count_d1;
    logic              w_pause_d0;
    logic              w_pause_d1;
    logic              w_ovf_d0;
    logic              w_ovf_d1;
    logic              w_unf_d0;
    logic              w_unf_d1;

    // Demux: MSB picks the destination; a full destination drops the word.
    assign w_dest        = bus_if.data_in[DATA_W-1];
    assign w_req_d0      = bus_if.valid_in && !w_dest;
    assign w_req_d1      = bus_if.valid_in &&  w_dest;
    assign w_push_d0_nxt = w_req_d0 && !w_full_d0;
    assign w_push_d1_nxt = w_req_d1 && !w_full_d1;
    assign w_drop_d0     = w_req_d0 &&  w_full_d0;
    assign w_drop_d1     = w_req_d1 &&  w_full_d1;

    // Output register: one-cycle push strobe, word held between pushes.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_push_d0 <= w_push_d0_nxt;
            r_push_d1 <= w_push_d1_nxt;
            if (w_push_d0_nxt || w_push_d1_nxt) begin
                r_data_out <= bus_if.data_in;
            end
        end
    end

    dest_pause_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_pause_d0 (
        .clk         (clk),
        .reset_L     (reset_L),
        .i_push      (r_push_d0),
        .i_pop       (bus_if.pop_d0),
        .i_drop      (w_drop_d0),
        .i_umbral_af (bus_if.umbral_af),
        .i_umbral_ae (bus_if.umbral_ae),
        .o_count     (w_count_d0),
        .o_pause     (w_pause_d0),
        .o_full      (w_full_d0),
        .o_ovf       (w_ovf_d0),
        .o_unf       (w_unf_d0)
    );

    dest_pause_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_pause_d1 (
        .clk         (clk),
        .reset_L     (reset_L),
        .i_push      (r_push_d1),
        .i_pop       (bus_if.pop_d1),
        .i_drop      (w_drop_d1),
        .i_umbral_af (bus_if.umbral_af),
        .i_umbral_ae (bus_if.umbral_ae),
        .o_count     (w_count_d1),
        .o_pause     (w_pause_d1),
        .o_full      (w_full_d1),
        .o_ovf       (w_ovf_d1),
        .o_unf       (w_unf_d1)
    );

    assign bus_if.push_d0       = r_push_d0;
    assign bus_if.push_d1       = r_push_d1;
    assign bus_if.data_out      = r_data_out;
    assign bus_if.pause_d0      = w_pause_d0;
    assign bus_if.pause_d1      = w_pause_d1;
    assign bus_if.count_d0      = w_count_d0;
    assign bus_if.count_d1      = w_count_d1;
    assign bus_if.overflow_err  = w_ovf_d0 || w_ovf_d1;
    assign bus_if.underflow_err = w_unf_d0 || w_unf_d1;
    assign bus_if.idle          = (w_count_d0 == '0) && (w_count_d1 == '0) &&
                                  !r_push_d0 && !r_push_d1;

endmodule : dest_flow_ctrl
`default_nettype wire

// File: tb/tb_dest_flow_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dest_flow_ctrl
// Brief    : Self-checking bench for dest_flow_ctrl (DEPTH=8, af=6, ae=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dest_flow_ctrl;
    import dest_flow_ctrl_pkg::*;

    localparam int DATA_W = DEF_DATA_W;
    localparam int DEPTH  = DEF_DEPTH;
    localparam int CNT_W  = DEF_CNT_W;

    logic clk = 1'b0;
    logic reset_L;

    always #5 clk = ~clk;

    dest_flow_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    dest_flow_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus_if  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0] mon_exp;

    typedef struct {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              pop0;
        logic              pop1;
        logic              e_push0;
        logic              e_push1;
        logic [CNT_W-1:0]  e_cnt0;
        logic [CNT_W-1:0]  e_cnt1;
        logic              e_pause0;
        logic              e_pause1;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic v, input logic [DATA_W-1:0] d, input logic p0,
                                input logic p1, input logic ep0, input logic ep1,
                                input int c0, input int c1, input logic pa0, input logic pa1);
        vec_t r;
        r.valid = v; r.data = d; r.pop0 = p0; r.pop1 = p1;
        r.e_push0 = ep0; r.e_push1 = ep1;
        r.e_cnt0 = CNT_W'(c0); r.e_cnt1 = CNT_W'(c1);
        r.e_pause0 = pa0; r.e_pause1 = pa1;
        return r;
    endfunction

    // {push0,push1,pause0,pause1,ovf,unf,idle,count0,count1,data_out}
    function automatic logic [31:0] pack(input logic p0, input logic p1, input logic pa0,
                                         input logic pa1, input logic ov, input logic un,
                                         input logic id, input logic [CNT_W-1:0] c0,
                                         input logic [CNT_W-1:0] c1, input logic [DATA_W-1:0] d);
        return {11'd0, p0, p1, pa0, pa1, ov, un, id, c0, c1, d};
    endfunction

    function automatic logic [31:0] observed();
        return pack(bus.push_d0, bus.push_d1, bus.pause_d0, bus.pause_d1,
                    bus.overflow_err, bus.underflow_err, bus.idle,
                    bus.count_d0, bus.count_d1, bus.data_out);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit expect_push);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        if (expect_push) sb_q.push_back(d);
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic do_reset();
        bus.valid_in = 1'b0;
        bus.pop_d0   = 1'b0;
        bus.pop_d1   = 1'b0;
        reset_L      = 1'b0;
        repeat (2) tick();
        reset_L = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: every push must match the oldest expected word.
    always @(negedge clk) begin
        if (reset_L === 1'b1 && (bus.push_d0 === 1'b1 || bus.push_d1 === 1'b1)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_push", {30'd0, bus.push_d0, bus.push_d1}, 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("sb_push_word", {24'd0, bus.push_d0, bus.push_d1, bus.data_out},
                    {24'd0, ~mon_exp[DATA_W-1], mon_exp[DATA_W-1], mon_exp});
            end
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] last_data;
        logic              e_idle;

        // Fill, then hysteresis drain, then one d1 word.
        vecs[0]  = mk(1, 6'h05, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 6'h0A, 0, 0, 1, 0, 1, 0, 0, 0);
        vecs[2]  = mk(1, 6'h13, 0, 0, 1, 0, 2, 0, 0, 0);
        vecs[3]  = mk(1, 6'h1F, 0, 0, 1, 0, 3, 0, 0, 0);
        vecs[4]  = mk(1, 6'h00, 0, 0, 1, 0, 4, 0, 0, 0);
        vecs[5]  = mk(1, 6'h1C, 0, 0, 1, 0, 5, 0, 0, 0);
        vecs[6]  = mk(0, 6'h3F, 0, 0, 0, 0, 6, 0, 0, 0);
        vecs[7]  = mk(0, 6'h3F, 0, 0, 0, 0, 6, 0, 1, 0);
        vecs[8]  = mk(0, 6'h00, 1, 0, 0, 0, 5, 0, 1, 0);
        vecs[9]  = mk(0, 6'h00, 1, 0, 0, 0, 4, 0, 1, 0);
        vecs[10] = mk(0, 6'h00, 1, 0, 0, 0, 3, 0, 1, 0);
        vecs[11] = mk(0, 6'h00, 1, 0, 0, 0, 2, 0, 1, 0);
        vecs[12] = mk(1, 6'h2A, 0, 0, 0, 1, 2, 0, 0, 0);
        vecs[13] = mk(0, 6'h11, 0, 0, 0, 0, 2, 1, 0, 0);

        bus.umbral_af = CNT_W'(6);
        bus.umbral_ae = CNT_W'(2);
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.pop_d0    = 1'b0;
        bus.pop_d1    = 1'b0;
        reset_L       = 1'b0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            bus.valid_in = 1'($urandom);
            bus.data_in  = DATA_W'($urandom);
            bus.pop_d0   = 1'($urandom);
            bus.pop_d1   = 1'($urandom);
            tick();
            chk("reset_hold", observed(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        bus.valid_in = 1'b0;
        bus.pop_d0   = 1'b0;
        bus.pop_d1   = 1'b0;
        reset_L      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_release", observed(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        end

        // Table-driven cycles.
        last_data = '0;
        for (int i = 0; i < 14; i++) begin
            bus.valid_in = vecs[i].valid;
            bus.data_in  = vecs[i].data;
            bus.pop_d0   = vecs[i].pop0;
            bus.pop_d1   = vecs[i].pop1;
            if (vecs[i].valid) begin
                sb_q.push_back(vecs[i].data);
                last_data = vecs[i].data;
            end
            tick();
            e_idle = (vecs[i].e_cnt0 == '0) && (vecs[i].e_cnt1 == '0) &&
                     !vecs[i].e_push0 && !vecs[i].e_push1;
            chk($sformatf("vec%0d", i), observed(),
                pack(vecs[i].e_push0, vecs[i].e_push1, vecs[i].e_pause0, vecs[i].e_pause1,
                     0, 0, e_idle, vecs[i].e_cnt0, vecs[i].e_cnt1, last_data));
        end
        bus.valid_in = 1'b0;
        bus.pop_d0   = 1'b0;
        bus.pop_d1   = 1'b0;

        // Simultaneous push and pop on d1 at count 5.
        do_reset();
        for (int i = 0; i < 5; i++) send(DATA_W'(6'h20 + i), 1'b1);
        repeat (2) tick();
        chk("simul_pre_count", 32'(bus.count_d1), 32'd5);
        chk("simul_pre_pause", 32'(bus.pause_d1), 32'd0);
        send(6'h3B, 1'b1);
        chk("simul_push_seen", 32'(bus.push_d1), 32'd1);
        bus.pop_d1 = 1'b1;
        tick();
        bus.pop_d1 = 1'b0;
        chk("simul_count", 32'(bus.count_d1), 32'd5);
        tick();
        chk("simul_count_hold", 32'(bus.count_d1), 32'd5);
        chk("simul_pause", 32'(bus.pause_d1), 32'd0);

        // Overflow and underflow.
        do_reset();
        for (int i = 0; i < 8; i++) send(DATA_W'(i + 1), 1'b1);
        chk("ovf_not_yet", 32'(bus.overflow_err), 32'd0);
        send(6'h0F, 1'b0);
        chk("ovf_set", 32'(bus.overflow_err), 32'd1);
        chk("ovf_push_suppressed", 32'(bus.push_d0), 32'd0);
        tick();
        chk("ovf_count_full", 32'(bus.count_d0), 32'd8);
        chk("ovf_pause", 32'(bus.pause_d0), 32'd1);
        bus.pop_d0 = 1'b1;
        tick();
        bus.pop_d0 = 1'b0;
        chk("ovf_count_after_pop", 32'(bus.count_d0), 32'd7);
        chk("ovf_sticky", 32'(bus.overflow_err), 32'd1);
        chk("unf_not_yet", 32'(bus.underflow_err), 32'd0);
        bus.pop_d1 = 1'b1;
        tick();
        bus.pop_d1 = 1'b0;
        chk("unf_set", 32'(bus.underflow_err), 32'd1);
        chk("unf_count_zero", 32'(bus.count_d1), 32'd0);
        tick();
        chk("unf_sticky", 32'(bus.underflow_err), 32'd1);

        // Asynchronous reset in the middle of traffic.
        do_reset();
        for (int i = 0; i < 6; i++) send(DATA_W'(6'h08 + i), 1'b1);
        repeat (2) tick();
        chk("mid_pause_set", 32'(bus.pause_d0), 32'd1);
        bus.pop_d0 = 1'b1;
        repeat (2) tick();
        bus.pop_d0 = 1'b0;
        chk("mid_count4", 32'(bus.count_d0), 32'd4);
        chk("mid_pause_held", 32'(bus.pause_d0), 32'd1);
        send(6'h07, 1'b0);
        chk("mid_inflight", 32'(bus.push_d0), 32'd1);
        #1 reset_L = 1'b0;
        #1;
        chk("mid_async_reset", observed(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        repeat (2) tick();
        reset_L = 1'b1;
        repeat (2) tick();
        chk("mid_after_release", observed(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        send(6'h25, 1'b1);
        chk("mid_first_push", 32'(bus.push_d1), 32'd1);
        tick();
        chk("mid_first_count", 32'(bus.count_d1), 32'd1);

        repeat (3) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dest_flow_ctrl
`default_nettype wire

// File: doc/dest_flow_ctrl.md
DEST_FLOW_CTRL -- requirements
Module: dest_flow_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 6, data word width; MSB selects destination (0 -> d0, 1 -> d1).
  DEPTH, 8, entries per destination FIFO.
  CNT_W, 4, occupancy counter width, equal to clog2(DEPTH)+1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state on rising edge.
  reset_L  in  1  asynchronous, active-low reset.
  valid_in  in  1  word present on data_in (from VC pop path).
  data_in  in  DATA_W  incoming word.
  pop_d0 / pop_d1  in  1  downstream reader consumed one d0/d1 entry.
  umbral_af  in  CNT_W  almost-full threshold (static config).
  umbral_ae  in  CNT_W  almost-empty threshold (static config); umbral_ae < umbral_af.
  push_d0 / push_d1  out  1  registered write strobe to the d0/d1 FIFO.
  data_out  out  DATA_W  registered word accompanying push_dX.
  pause_d0 / pause_d1  out  1  back-pressure to the VC pop logic.
  count_d0 / count_d1  out  CNT_W  tracked occupancy.
  overflow_err / underflow_err  out  1  sticky error flags.
  idle  out  1  both counts 0 and no push pending.

Function
REQ-003 valid_in=1 at edge N SHALL produce push_dX=1 and data_out=data_in during cycle N+1, with X given by data_in[DATA_W-1]; exactly one push per valid_in.
REQ-004 valid_in=0 SHALL give push_d0=push_d1=0 next cycle; data_out SHALL hold its last value.
REQ-005 count_dX SHALL increment on an edge with push_dX=1 and pop_dX=0, decrement on pop_dX=1 and push_dX=0, and hold when both or neither are active.
REQ-006 A push routed to dX while count_dX==DEPTH SHALL be suppressed (push_dX stays 0), leave count_dX unchanged, and set overflow_err.
REQ-007 pop_dX while count_dX==0 and push_dX==0 SHALL leave count_dX at 0 and set underflow_err.
REQ-008 Each destination SHALL have a two-state FSM: NORMAL and PAUSED.
REQ-009 NORMAL->PAUSED SHALL occur at the edge where the registered count_dX >= umbral_af; PAUSED->NORMAL SHALL occur at the edge where count_dX <= umbral_ae; otherwise the state holds.
REQ-010 pause_dX SHALL be 1 exactly when its FSM is PAUSED (decoded from a register, no combinational input path).
REQ-011 Latency SHALL be: valid_in at edge N -> count update at edge N+1 -> pause_dX change visible after edge N+2.
REQ-012 Words already in flight when pause rises (at most 2) SHALL still be pushed; DEPTH - umbral_af >= 2 is the documented config constraint.
REQ-013 overflow_err and underflow_err SHALL remain set until reset.
REQ-014 idle SHALL be 1 when count_d0==0, count_d1==0, and push_d0=push_d1=0.

Reset
REQ-015 reset_L=0 SHALL immediately, without waiting for a clock edge, force push_d0, push_d1, pause_d0, pause_d1, count_d0, count_d1, overflow_err, underflow_err and data_out to 0, set idle to 1, and place both FSMs in NORMAL.
REQ-016 Reset asserted mid-operation SHALL discard in-flight pushes; the first push after release SHALL come no earlier than one cycle after the first valid_in.

Structure
REQ-017 A shared package SHALL hold DATA_W, DEPTH, CNT_W defaults and the NORMAL/PAUSED state encoding.
REQ-018 The occupancy counter, FSM and error logic SHALL be one sub-module, dest_pause_ctrl, instantiated once per destination; the demux and output register SHALL be in the top module.

Verification (DEPTH=8, umbral_af=6, umbral_ae=2)
REQ-019 Reset: hold reset_L=0 with random inputs -> every output 0 except idle=1; release -> values stay unchanged until valid_in.
REQ-020 Fill: 6 words with MSB=0, no pops -> count_d0=6, pause_d0=1 one cycle later, pause_d1=0, count_d1=0.
REQ-021 Hysteresis: from the REQ-020 state, pop_d0 x3 -> count 3 with pause_d0 still 1; fourth pop -> count 2, pause_d0=0 the next cycle.
REQ-022 Simultaneous: count_d1=5 with push_d1 and pop_d1 on the same edge -> count_d1 stays 5 and pause_d1 is unchanged.
REQ-023 Errors: 9 words to d0 with no pops -> count_d0=8, ninth push suppressed, overflow_err=1 and sticky; pop_d1 at count_d1=0 -> underflow_err=1.
REQ-024 Reset mid-operation: count_d0=4, pause_d0=1, reset_L falls between edges -> count_d0=0 and pause_d0=0 before the next clock edge.
